// File: rtl/fwd_sel_gen.sv
// Operand-forwarding select generator: tracks destination registers through
// EX/MEM/WB and produces registered 4:1 operand-mux selects plus a load-use stall.
module fwd_sel_gen #(
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            freeze,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    output logic [1:0]      ex_fwd_a_sel,
    output logic [1:0]      ex_fwd_b_sel,
    output logic            ex_valid,
    output logic            load_stall
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_WBH   = 2'b11;

    // Tracking stages. A load in WB has already returned its data, so the
    // WB stage keeps no memread bit.
    logic            ex_valid_r, ex_regwrite_r, ex_memread_r;
    logic [RA_W-1:0] ex_rd_r;
    logic            mem_valid_r, mem_regwrite_r, mem_memread_r;
    logic [RA_W-1:0] mem_rd_r;
    logic            wb_valid_r, wb_regwrite_r;
    logic [RA_W-1:0] wb_rd_r;
    logic [1:0]      sel_a_r, sel_b_r;

    logic            load_stall_s;
    logic            bubble_s;
    logic [1:0]      sel_a_s, sel_b_s;

    function automatic logic stage_hit(
        input logic            use_rs,
        input logic [RA_W-1:0] rs,
        input logic            valid,
        input logic [RA_W-1:0] rd,
        input logic            regwrite
    );
        stage_hit = use_rs & valid & regwrite & (rd == rs) & (rs != {RA_W{1'b0}});
    endfunction

    // Newest producer wins.
    function automatic logic [1:0] pick_sel(
        input logic hit_ex,
        input logic hit_mem,
        input logic hit_wb
    );
        if (hit_ex) begin
            pick_sel = SEL_EXMEM;
        end else if (hit_mem) begin
            pick_sel = SEL_MEMWB;
        end else if (hit_wb) begin
            pick_sel = SEL_WBH;
        end else begin
            pick_sel = SEL_RF;
        end
    endfunction

    // Load-use hazard detection and next-cycle select computation.
    always_comb begin
        load_stall_s = id_valid & ex_valid_r & ex_memread_r & ex_regwrite_r
                     & (ex_rd_r != {RA_W{1'b0}})
                     & ((id_use_rs1 & (id_rs1 == ex_rd_r)) | (id_use_rs2 & (id_rs2 == ex_rd_r)));
        bubble_s = flush | load_stall_s | ~id_valid;
        if (bubble_s) begin
            sel_a_s = SEL_RF;
            sel_b_s = SEL_RF;
        end else begin
            sel_a_s = pick_sel(
                stage_hit(id_use_rs1, id_rs1, ex_valid_r,  ex_rd_r,  ex_regwrite_r),
                stage_hit(id_use_rs1, id_rs1, mem_valid_r, mem_rd_r, mem_regwrite_r),
                stage_hit(id_use_rs1, id_rs1, wb_valid_r,  wb_rd_r,  wb_regwrite_r));
            sel_b_s = pick_sel(
                stage_hit(id_use_rs2, id_rs2, ex_valid_r,  ex_rd_r,  ex_regwrite_r),
                stage_hit(id_use_rs2, id_rs2, mem_valid_r, mem_rd_r, mem_regwrite_r),
                stage_hit(id_use_rs2, id_rs2, wb_valid_r,  wb_rd_r,  wb_regwrite_r));
        end
    end

    // Pipeline tracking shift and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_rd_r        <= {RA_W{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            mem_rd_r       <= {RA_W{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_regwrite_r  <= 1'b0;
            wb_rd_r        <= {RA_W{1'b0}};
            sel_a_r        <= SEL_RF;
            sel_b_r        <= SEL_RF;
        end else if (!freeze) begin
            wb_valid_r     <= mem_valid_r & ~mem_memread_r | mem_valid_r & mem_memread_r;
            wb_regwrite_r  <= mem_regwrite_r;
            wb_rd_r        <= mem_rd_r;
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memread_r  <= ex_memread_r;
            mem_rd_r       <= ex_rd_r;
            sel_a_r        <= sel_a_s;
            sel_b_r        <= sel_b_s;
            if (bubble_s) begin
                ex_valid_r    <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_rd_r       <= {RA_W{1'b0}};
            end else begin
                ex_valid_r    <= 1'b1;
                ex_regwrite_r <= id_regwrite;
                ex_memread_r  <= id_memread;
                ex_rd_r       <= id_rd;
            end
        end
    end

    assign ex_fwd_a_sel = sel_a_r;
    assign ex_fwd_b_sel = sel_b_r;
    assign ex_valid     = ex_valid_r;
    assign load_stall   = load_stall_s;

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Table-driven scoreboard bench for fwd_sel_gen, plus hand-written
// reset, freeze and flush sequences.
module tb_fwd_sel_gen;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst_n, freeze, flush, id_valid;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic [1:0]      ex_fwd_a_sel, ex_fwd_b_sel;
    logic            ex_valid, load_stall;

    fwd_sel_gen #(.RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
        .ex_valid(ex_valid), .load_stall(load_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit frz, fl, v, u1, u2, rw, mr;
        logic [4:0] rd, rs1, rs2;
        bit st;
        logic [1:0] a, b;
        bit ev;
    } vec_t;

    typedef struct {
        int idx;
        logic [1:0] a, b;
        bit ev;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(bit frz, bit fl, bit v, int rd, int rs1, bit u1, int rs2, bit u2,
                                bit rw, bit mr, bit st, logic [1:0] a, logic [1:0] b, bit ev);
        vec_t t;
        t.frz = frz; t.fl = fl; t.v = v; t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr;
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.st = st; t.a = a; t.b = b; t.ev = ev;
        return t;
    endfunction

    function automatic vec_t alu(int rd, int rs1, int rs2, bit st, logic [1:0] a, logic [1:0] b, bit ev);
        return mk(1'b0, 1'b0, 1'b1, rd, rs1, 1'b1, rs2, 1'b1, 1'b1, 1'b0, st, a, b, ev);
    endfunction

    function automatic vec_t lw(int rd, int rs1, logic [1:0] a);
        return mk(1'b0, 1'b0, 1'b1, rd, rs1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, a, 2'b00, 1'b1);
    endfunction

    task automatic check(string name, int idx, logic [1:0] act, logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0b expected %0b", name, idx, act, exp);
    endtask

    task automatic drive(vec_t t);
        freeze = t.frz; flush = t.fl; id_valid = t.v;
        id_rd = t.rd; id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_use_rs1 = t.u1; id_use_rs2 = t.u2;
        id_regwrite = t.rw; id_memread = t.mr;
    endtask

    task automatic run_vec(vec_t t, int idx);
        exp_t e;
        @(negedge clk);
        drive(t);
        #1;
        check("load_stall", idx, {1'b0, load_stall}, {1'b0, t.st});
        sb.push_back('{idx, t.a, t.b, t.ev});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ex_fwd_a_sel", e.idx, ex_fwd_a_sel, e.a);
        check("ex_fwd_b_sel", e.idx, ex_fwd_b_sel, e.b);
        check("ex_valid", e.idx, {1'b0, ex_valid}, {1'b0, e.ev});
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_a"}, -1, ex_fwd_a_sel, 2'b00);
        check({tag, "_b"}, -1, ex_fwd_b_sel, 2'b00);
        check({tag, "_valid"}, -1, {1'b0, ex_valid}, 2'b00);
        check({tag, "_stall"}, -1, {1'b0, load_stall}, 2'b00);
    endtask

    initial begin
        // back-to-back dependency, then distance-1/2/3 producers
        vecs.push_back(alu(5, 1, 2, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(6, 5, 5, 0, 2'b01, 2'b01, 1));
        vecs.push_back(alu(7, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(10, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(11, 1, 7, 0, 2'b00, 2'b10, 1));
        vecs.push_back(alu(7, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(12, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(13, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(14, 1, 7, 0, 2'b00, 2'b11, 1));
        vecs.push_back(alu(7, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(15, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(16, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(17, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(18, 1, 7, 0, 2'b00, 2'b00, 1));
        // load-use: stall, bubble, then MEM/WB forward
        vecs.push_back(lw(8, 1, 2'b00));
        vecs.push_back(alu(19, 8, 2, 1, 2'b00, 2'b00, 0));
        vecs.push_back(alu(19, 8, 2, 0, 2'b10, 2'b00, 1));
        // x9 in both EX and MEM: newest wins; x0 never forwarded
        vecs.push_back(alu(9, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(9, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(20, 9, 9, 0, 2'b01, 2'b01, 1));
        vecs.push_back(alu(0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(0, 1, 1, 0, 2'b00, 2'b00, 1));
        vecs.push_back(alu(21, 0, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(lw(0, 1, 2'b00));
        vecs.push_back(alu(22, 0, 0, 0, 2'b00, 2'b00, 1));
        // id_valid=0 bubble, then use flags
        vecs.push_back(mk(0, 0, 0, 23, 22, 1, 22, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(alu(23, 22, 3, 0, 2'b10, 2'b00, 1));
        vecs.push_back(mk(0, 0, 1, 24, 23, 0, 23, 1, 1, 0, 0, 2'b00, 2'b01, 1));
        // freeze three cycles with a load-use pending
        vecs.push_back(lw(25, 1, 2'b00));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 1, 26, 25, 1, 1, 1, 1, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(alu(26, 25, 1, 1, 2'b00, 2'b00, 0));
        vecs.push_back(alu(26, 25, 1, 0, 2'b10, 2'b00, 1));
        // flush while load_stall is high: bubble, no repeated stall
        vecs.push_back(lw(27, 1, 2'b00));
        vecs.push_back(mk(0, 1, 1, 28, 27, 1, 27, 1, 1, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(alu(29, 1, 2, 0, 2'b00, 2'b00, 1));
        vecs.push_back(lw(30, 29, 2'b01));

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // mid-stream reset overrides freeze, flush and a pending stall
        @(negedge clk);
        drive(mk(1, 1, 1, 1, 30, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        #1;
        check("pre_reset_stall", -1, {1'b0, load_stall}, 2'b01);
        check("pre_reset_a", -1, ex_fwd_a_sel, 2'b01);
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        @(posedge clk);
        #1;
        check_cleared("held_reset");
        #1 rst_n = 1'b1;
        run_vec(alu(31, 30, 30, 0, 2'b00, 2'b00, 1), 100);
        run_vec(alu(2, 31, 0, 0, 2'b01, 2'b00, 1), 101);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
